// File: rtl/wb_arbiter2_if.sv
// Wishbone B3 point-to-point bundle; master drives request fields, slave drives the response.
interface wb_arbiter2_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic [SW-1:0] sel;
  logic          we;
  logic          cyc;
  logic          stb;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  logic          err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone B3 arbiter: grants span a whole cyc envelope,
// a stall watchdog errors out hung slave accesses and drains the owner.
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter2_if.slave  m0,
  wb_arbiter2_if.slave  m1,
  wb_arbiter2_if.master s,
  output logic [1:0]    grant_o
);
  localparam int unsigned    WDW     = 16;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic           owner_q, owner_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [1:0]     grant_d;
  logic           stall_c;

  // Arbitration state, round-robin history, drain owner, watchdog and grant flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      wdog_q  <= '0;
      grant_o <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      wdog_q  <= wdog_d;
      grant_o <= grant_d;
    end
  end

  // Next state, bus steering to/from the owner, watchdog count
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    wdog_d   = '0;
    grant_d  = 2'b00;
    stall_c  = 1'b0;
    s.adr    = '0;
    s.dat_w  = '0;
    s.sel    = '0;
    s.we     = 1'b0;
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.cti    = '0;
    s.bte    = '0;
    m0.dat_r = '0;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m1.dat_r = '0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;

    case (state_q)
      IDLE: begin
        // Both requesting: the master not served last wins
        if (m0.cyc && (!m1.cyc || last_q)) begin
          state_d = OWN0;
          owner_d = 1'b0;
          grant_d = 2'b01;
        end else if (m1.cyc) begin
          state_d = OWN1;
          owner_d = 1'b1;
          grant_d = 2'b10;
        end
      end

      OWN0: begin
        s.adr    = m0.adr;
        s.dat_w  = m0.dat_w;
        s.sel    = m0.sel;
        s.we     = m0.we;
        s.cyc    = m0.cyc;
        s.stb    = m0.stb;
        s.cti    = m0.cti;
        s.bte    = m0.bte;
        m0.dat_r = s.dat_r;
        m0.ack   = s.ack;
        m0.err   = s.err;
        stall_c  = m0.stb && !s.ack && !s.err;
        if (!m0.cyc) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (stall_c && (wdog_q == WD_LAST)) begin
          m0.err  = 1'b1;
          state_d = DRAIN;
        end else begin
          grant_d = 2'b01;
          if (stall_c) wdog_d = wdog_q + WDW'(1);
        end
      end

      OWN1: begin
        s.adr    = m1.adr;
        s.dat_w  = m1.dat_w;
        s.sel    = m1.sel;
        s.we     = m1.we;
        s.cyc    = m1.cyc;
        s.stb    = m1.stb;
        s.cti    = m1.cti;
        s.bte    = m1.bte;
        m1.dat_r = s.dat_r;
        m1.ack   = s.ack;
        m1.err   = s.err;
        stall_c  = m1.stb && !s.ack && !s.err;
        if (!m1.cyc) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (stall_c && (wdog_q == WD_LAST)) begin
          m1.err  = 1'b1;
          state_d = DRAIN;
        end else begin
          grant_d = 2'b10;
          if (stall_c) wdog_d = wdog_q + WDW'(1);
        end
      end

      DRAIN: begin
        // Bus is released; late slave responses are swallowed until the owner lets go
        if (owner_q ? !m1.cyc : !m0.cyc) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end
endmodule
